rx_flow_scheduler: RTL

RX_FLOW_SCHEDULER -- requirements
Module: rx_flow_scheduler

---
 rtl/rx_flow_scheduler.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/rx_flow_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rx_flow_scheduler
// Description : Per-flow receive queueing with a round-robin scheduler.
//               Incoming RPC packets are steered into one FIFO per flow and
//               drained one packet per cycle through a single registered
//               output stage with valid/ready handshake.
// Ports       : clk, reset               - clock, synchronous active-high reset
//               number_of_flows          - active flow count (0 = all flows)
//               start                    - enables granting to the output
//               rpc_in / _valid / flow_id_in
//                                        - input packet, no backpressure
//               rpc_out / _valid / _ready / flow_id_out
//                                        - scheduled packet handshake
//               pdrop_out, pdrop_cnt     - drop pulse and saturating count
//               empty_out                - all FIFOs and output stage empty
// Revision    : 1.0 - initial release
// ============================================================================
module rx_flow_scheduler #(
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LFLOW_DEPTH       = 2,
  parameter int PKT_WIDTH         = 512
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  logic                         start,
  input  logic [PKT_WIDTH-1:0]         rpc_in,
  input  logic                         rpc_in_valid,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in,
  output logic [PKT_WIDTH-1:0]         rpc_out,
  output logic                         rpc_out_valid,
  input  logic                         rpc_out_ready,
  output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
  output logic                         pdrop_out,
  output logic [31:0]                  pdrop_cnt,
  output logic                         empty_out
);

  localparam int FW    = LMAX_NUM_OF_FLOWS;
  localparam int NF    = 1 << FW;
  localparam int DEPTH = 1 << LFLOW_DEPTH;
  localparam int PW    = LFLOW_DEPTH + 1;
  localparam logic [FW:0] NF_CNT = (FW+1)'(NF);

  // --------------------------------------------------------------------------
  // Effective flow count (one bit wider so that "all flows" is representable)
  // --------------------------------------------------------------------------
  logic [FW:0] eff_cnt;
  assign eff_cnt = (number_of_flows == '0) ? NF_CNT : {1'b0, number_of_flows};

  // --------------------------------------------------------------------------
  // Per-flow status and control vectors
  // --------------------------------------------------------------------------
  logic [NF-1:0]                fifo_empty;
  logic [NF-1:0]                fifo_full;
  logic [NF-1:0]                wr_en;
  logic [NF-1:0]                pop_en;
  logic [NF-1:0][PKT_WIDTH-1:0] fifo_head;

  // Output stage registers
  logic                 out_valid_q, out_valid_d;
  logic [PKT_WIDTH-1:0] out_data_q,  out_data_d;
  logic [FW-1:0]        out_id_q,    out_id_d;
  logic [FW-1:0]        rr_ptr_q,    rr_ptr_d;
  logic                 pdrop_q,     pdrop_d;
  logic [31:0]          pdrop_cnt_q, pdrop_cnt_d;

  // --------------------------------------------------------------------------
  // Input admission. Fullness is taken from the registered pointers, so a
  // pop in the same cycle never makes room for an incoming packet.
  // --------------------------------------------------------------------------
  logic id_oob;
  logic tgt_full;
  logic drop;
  logic accept;

  assign id_oob   = ({1'b0, rpc_flow_id_in} >= eff_cnt);
  assign tgt_full = fifo_full[rpc_flow_id_in];
  assign drop     = rpc_in_valid && (id_oob || tgt_full);
  assign accept   = rpc_in_valid && !drop;

  // --------------------------------------------------------------------------
  // Round-robin arbiter
  // --------------------------------------------------------------------------
  logic          out_load;
  logic          found;
  logic          grant;
  logic [FW-1:0] grant_idx;
  logic [FW:0]   rr_base;
  logic [FW:0]   cand;
  logic [FW:0]   rr_nxt;

  // The output register can take a new packet when it is empty or its
  // current packet is being accepted this cycle.
  assign out_load = !out_valid_q || rpc_out_ready;

  // A pointer left beyond the active range (after the flow count was
  // reduced) restarts the search from flow 0.
  assign rr_base = ({1'b0, rr_ptr_q} >= eff_cnt) ? '0 : {1'b0, rr_ptr_q};

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NF; k++) begin
      // rr_base < eff_cnt and k < eff_cnt, so one subtraction wraps it.
      cand = rr_base + (FW+1)'(k);
      if (cand >= eff_cnt) begin
        cand = cand - eff_cnt;
      end
      if (!found && ((FW+1)'(k) < eff_cnt) && (cand < eff_cnt) &&
          !fifo_empty[cand[FW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[FW-1:0];
      end
    end
  end

  assign grant  = out_load && start && found;
  assign rr_nxt = {1'b0, grant_idx} + (FW+1)'(1);

  // --------------------------------------------------------------------------
  // Per-flow FIFOs
  // --------------------------------------------------------------------------
  for (genvar f = 0; f < NF; f++) begin : g_flow
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [PKT_WIDTH-1:0] mem_q [DEPTH];

    assign wr_en[f]      = accept && (rpc_flow_id_in == FW'(f));
    assign pop_en[f]     = grant && (grant_idx == FW'(f));
    assign fifo_empty[f] = (wr_ptr_q == rd_ptr_q);
    // Extra pointer bit distinguishes full from empty when indices match.
    assign fifo_full[f]  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                           (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign fifo_head[f]  = mem_q[rd_ptr_q[PW-2:0]];

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en[f]) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (pop_en[f]) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
      end
    end

    // Storage carries no reset; occupancy is defined solely by the pointers.
    always_ff @(posedge clk) begin
      if (wr_en[f]) begin
        mem_q[wr_ptr_q[PW-2:0]] <= rpc_in;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic for output stage, round-robin pointer and drop tracking
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    pdrop_d     = drop;
    pdrop_cnt_d = pdrop_cnt_q;

    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_head[grant_idx];
      out_id_d    = grant_idx;
      rr_ptr_d    = (rr_nxt >= eff_cnt) ? '0 : rr_nxt[FW-1:0];
    end else if (out_load) begin
      // Either already empty or the held packet was just accepted.
      out_valid_d = 1'b0;
    end

    if (drop && (pdrop_cnt_q != 32'hFFFF_FFFF)) begin
      pdrop_cnt_d = pdrop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
      pdrop_q     <= 1'b0;
      pdrop_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
      pdrop_q     <= pdrop_d;
      pdrop_cnt_q <= pdrop_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rpc_out         = out_data_q;
  assign rpc_out_valid   = out_valid_q;
  assign rpc_flow_id_out = out_id_q;
  assign pdrop_out       = pdrop_q;
  assign pdrop_cnt       = pdrop_cnt_q;
  assign empty_out       = (&fifo_empty) && !out_valid_q;

endmodule
`default_nettype wire
